// File: rtl/oaum_pkg.sv
// Shared definitions for the iterative approximate mantissa multiplier family.
// Holds the FSM state type and sizing/clamping helpers reused across OAM blocks.
package oaum_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } oaum_state_e;

   // Accumulator fraction width: enough bits that every radix-4 partial product is exact.
   function automatic int unsigned calc_fw(input int unsigned mw, input int unsigned max_acc);
      return mw + 2 * max_acc;
   endfunction

   function automatic int unsigned clamp_level(input int unsigned lvl,
                                               input int unsigned max_acc);
      return (lvl > max_acc) ? max_acc : lvl;
   endfunction

endpackage

// File: rtl/oaum_r4_step.sv
// One radix-4 partial product of the X*Y cross term, aligned to the accumulator LSB.
// addend = X * digit * 2^-(2(k+1)), with X taken as a fraction of MW bits.
module oaum_r4_step
   import oaum_pkg::*;
#(
   parameter int unsigned MANTISSA_WIDTH = 15,
   parameter int unsigned MAX_ACC = 4,
   localparam int unsigned ACC_W = $clog2(MAX_ACC + 1),
   localparam int unsigned AW = calc_fw(MANTISSA_WIDTH, MAX_ACC) + 2
) (
   input  logic [MANTISSA_WIDTH-1:0] x,
   input  logic [1:0]                digit,
   input  logic [ACC_W-1:0]          k,
   output logic [AW-1:0]             addend
);

   // k never exceeds MAX_ACC-1, so the shift amount stays non-negative.
   always_comb begin
      addend = (AW'(x) * AW'(digit)) << (2 * MAX_ACC - 2 - 2 * 32'(k));
   end

endmodule

// File: rtl/mantissa_oaum_iter.sv
// Sequential approximate mantissa multiplier: 1 + X + Y + X*Y_hi, one radix-4 digit of Y
// per cycle, with a per-transaction accuracy level and valid/ready on both sides.
module mantissa_oaum_iter
   import oaum_pkg::*;
#(
   parameter int unsigned MANTISSA_WIDTH = 15,
   parameter int unsigned MAX_ACC = 4,
   localparam int unsigned ACC_W = $clog2(MAX_ACC + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [MANTISSA_WIDTH-1:0] Mantissa_X,
   input  logic [MANTISSA_WIDTH-1:0] Mantissa_Y,
   input  logic [ACC_W-1:0]          Acc_Level,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [MANTISSA_WIDTH-1:0] Mantissa_Out,
   output logic [1:0]                Shift
);

   localparam int unsigned MW = MANTISSA_WIDTH;
   localparam int unsigned FW = calc_fw(MW, MAX_ACC);
   localparam int unsigned AW = FW + 2;

   oaum_state_e       state_q;
   logic [MW-1:0]     x_q;
   logic [MW-1:0]     y_q;
   logic [ACC_W-1:0]  lvl_q;
   logic [ACC_W-1:0]  k_q;
   logic [AW-1:0]     acc_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [MW-1:0]     mant_q;
   logic [1:0]        shift_q;

   logic [ACC_W-1:0]  lvl_in;
   logic [AW-1:0]     acc_load;
   logic [1:0]        digit;
   logic [AW-1:0]     addend;
   logic [AW-1:0]     acc_sum;
   logic              last_digit;
   logic [AW-1:0]     norm_src;
   logic [MW-1:0]     norm_mant;
   logic [1:0]        norm_shift;

   oaum_r4_step #(
      .MANTISSA_WIDTH(MANTISSA_WIDTH),
      .MAX_ACC       (MAX_ACC)
   ) u_step (
      .x     (x_q),
      .digit (digit),
      .k     (k_q),
      .addend(addend)
   );

   always_comb begin
      lvl_in     = ACC_W'(clamp_level(32'(Acc_Level), MAX_ACC));
      acc_load   = (AW'(1) << FW) + (AW'(Mantissa_X) << (FW - MW))
                 + (AW'(Mantissa_Y) << (FW - MW));
      digit      = 2'(y_q >> (MW - 2 - 2 * 32'(k_q)));
      acc_sum    = acc_q + addend;
      last_digit = (k_q == lvl_q - ACC_W'(1));
      // Results are registered on entry to DONE, so normalise the value being written.
      norm_src   = (state_q == StIdle) ? acc_load : acc_sum;
      if (norm_src[FW+1]) begin
         norm_mant  = norm_src[FW -: MW];
         norm_shift = 2'b01;
      end else begin
         norm_mant  = norm_src[FW-1 -: MW];
         norm_shift = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         x_q         <= '0;
         y_q         <= '0;
         lvl_q       <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mant_q      <= '0;
         shift_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  x_q        <= Mantissa_X;
                  y_q        <= Mantissa_Y;
                  lvl_q      <= lvl_in;
                  k_q        <= '0;
                  acc_q      <= acc_load;
                  in_ready_q <= 1'b0;
                  if (lvl_in == '0) begin
                     state_q     <= StDone;
                     out_valid_q <= 1'b1;
                     mant_q      <= norm_mant;
                     shift_q     <= norm_shift;
                  end else begin
                     state_q <= StAccum;
                  end
               end
            end
            StAccum: begin
               acc_q <= acc_sum;
               k_q   <= k_q + ACC_W'(1);
               if (last_digit) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
                  mant_q      <= norm_mant;
                  shift_q     <= norm_shift;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign Mantissa_Out = mant_q;
   assign Shift        = shift_q;

endmodule

// File: tb/tb_mantissa_oaum_iter.sv
// Bench for mantissa_oaum_iter: directed vector table, closed-form random checks,
// backpressure hold and mid-transaction reset, all via an expected-result queue.
module tb_mantissa_oaum_iter;

   localparam int unsigned MW = 15;
   localparam int unsigned MAX_ACC = 4;

   typedef struct {
      logic [MW-1:0] mant;
      logic [1:0]    shift;
      int            lat;
   } exp_t;

   typedef struct {
      logic [MW-1:0] x;
      logic [MW-1:0] y;
      logic [2:0]    l;
      logic [MW-1:0] mant;
      logic [1:0]    shift;
      int            lat;
      int            stall;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] Mantissa_X;
   logic [MW-1:0] Mantissa_Y;
   logic [2:0]    Acc_Level;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] Mantissa_Out;
   logic [1:0]    Shift;

   int   n_cmp;
   int   n_fail;
   exp_t sb[$];
   vec_t vecs[8];

   mantissa_oaum_iter #(
      .MANTISSA_WIDTH(MW),
      .MAX_ACC       (MAX_ACC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Mantissa_X  (Mantissa_X),
      .Mantissa_Y  (Mantissa_Y),
      .Acc_Level   (Acc_Level),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Mantissa_Out(Mantissa_Out),
      .Shift       (Shift)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Closed form: 1 + X + Y + X*Y_hi in units of 2^-2MW, then truncating normalisation.
   function automatic exp_t model(input logic [MW-1:0] x, input logic [MW-1:0] y,
                                  input int l);
      exp_t          r;
      int            ll;
      logic [MW-1:0] mask;
      longint unsigned a;
      ll   = (l > int'(MAX_ACC)) ? int'(MAX_ACC) : l;
      mask = '1;
      mask = (ll == 0) ? '0 : (mask << (MW - 2 * ll));
      a = (64'd1 << (2 * MW)) + (64'(x) << MW) + (64'(y) << MW) + 64'(x) * 64'(y & mask);
      if (a >= (64'd2 << (2 * MW))) begin
         r.mant  = MW'(a >> (MW + 1));
         r.shift = 2'b01;
      end else begin
         r.mant  = MW'(a >> MW);
         r.shift = 2'b00;
      end
      r.lat = ll;
      return r;
   endfunction

   task automatic run_txn(input logic [MW-1:0] x, input logic [MW-1:0] y, input logic [2:0] l,
                          input logic [MW-1:0] em, input logic [1:0] es, input int el,
                          input int stall);
      exp_t e;
      int   lat;
      e.mant  = em;
      e.shift = es;
      e.lat   = el;
      sb.push_back(e);
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      Mantissa_X = x;
      Mantissa_Y = y;
      Acc_Level  = l;
      in_valid   = 1'b1;
      out_ready  = (stall == 0);
      @(posedge clk);
      #1;
      // Scramble inputs after the accept edge; the transaction must not see them.
      in_valid   = 1'b0;
      Acc_Level  = ~l;
      Mantissa_X = ~x;
      Mantissa_Y = ~y;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 16) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("mant", 32'(Mantissa_Out), 32'(e.mant));
      check("shift", 32'(Shift), 32'(e.shift));
      check("in_ready_busy", 32'(in_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_mant", 32'(Mantissa_Out), 32'(e.mant));
         check("hold_shift", 32'(Shift), 32'(e.shift));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t m;
      logic [MW-1:0] rx, ry;
      logic [2:0]    rl;
      n_cmp = 0;
      n_fail = 0;
      vecs[0] = '{15'h0000, 15'h0000, 3'd3, 15'h0000, 2'd0, 3, 0};
      vecs[1] = '{15'h4000, 15'h4000, 3'd0, 15'h0000, 2'd1, 0, 0};
      vecs[2] = '{15'h4000, 15'h4000, 3'd1, 15'h1000, 2'd1, 1, 0};
      vecs[3] = '{15'h7FFF, 15'h7FFF, 3'd0, 15'h3FFF, 2'd1, 0, 0};
      vecs[4] = '{15'h2000, 15'h6000, 3'd1, 15'h0C00, 2'd1, 1, 0};
      vecs[5] = '{15'h0000, 15'h7FFF, 3'd4, 15'h7FFF, 2'd0, 4, 0};
      vecs[6] = '{15'h4000, 15'h4000, 3'd7, 15'h1000, 2'd1, 4, 0};
      vecs[7] = '{15'h4000, 15'h4000, 3'd2, 15'h1000, 2'd1, 2, 5};

      rst_n      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      Mantissa_X = '0;
      Mantissa_Y = '0;
      Acc_Level  = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_mant", 32'(Mantissa_Out), 32'd0);
      check("rst_shift", 32'(Shift), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_txn(vecs[i].x, vecs[i].y, vecs[i].l, vecs[i].mant, vecs[i].shift, vecs[i].lat,
                 vecs[i].stall);

      for (int i = 0; i < 40; i++) begin
         rx = MW'($urandom);
         ry = MW'($urandom);
         rl = 3'($urandom_range(0, 7));
         m  = model(rx, ry, int'(rl));
         run_txn(rx, ry, rl, m.mant, m.shift, m.lat, 0);
      end

      // Reset mid-ACCUM aborts at once; nothing is queued for the aborted transaction.
      @(negedge clk);
      Mantissa_X = 15'h1234;
      Mantissa_Y = 15'h5678;
      Acc_Level  = 3'd4;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("accum_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      m = model(15'h6ABC, 15'h1357, 3);
      run_txn(15'h6ABC, 15'h1357, 3'd3, m.mant, m.shift, m.lat, 0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mantissa_oaum_iter.md
# mantissa_oaum_iter

Sequential, run-time-configurable successor to the combinational approximate mantissa multiplier. It computes the normalised mantissa of (1.X)·(1.Y), approximating the X·Y cross term with a per-transaction accuracy level. The level selects how many radix-4 digits of Y are consumed, one digit per cycle. It sits between exponent handling and normalisation in the approximate FP multiplier datapath and uses valid/ready handshakes on both sides.

## Interface
- MANTISSA_WIDTH, 15, fraction bits of X, Y and Mantissa_Out (MW).
- MAX_ACC, 4, maximum accuracy level; requires 2·MAX_ACC ≤ MW.
- ACC_W, $clog2(MAX_ACC+1), width of the acc level input (derived localparam; not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- Mantissa_X  in  MW  fraction of operand A (A = 1.X).
- Mantissa_Y  in  MW  fraction of operand B.
- Acc_Level  in  ACC_W  requested accuracy level L; values above MAX_ACC clamp to MAX_ACC.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Mantissa_Out  out  MW  normalised fraction of the product.
- Shift  out  2  exponent increment: 0 if product < 2, 1 if product ≥ 2; bit 1 is always 0.

## Operation
- Accumulator: 2 integer bits plus FW = MW + 2·MAX_ACC fraction bits, unsigned, no rounding. The value always stays below 4, so there is no overflow.
- FSM states IDLE, ACCUM and DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid the block latches X, Y and L = min(Acc_Level, MAX_ACC).
  - It loads acc = 1 + X·2^-MW + Y·2^-MW, clears digit index k = 0, and goes to ACCUM.
  - If L = 0 it goes straight to DONE instead.
- ACCUM:
  - Each cycle: d_k = Y[MW-1-2k : MW-2-2k] (radix-4 digit, 0..3).
  - Each cycle: acc += X·d_k·2^-(MW+2(k+1)), exact within FW; then k++.
  - After the digit with k = L-1 it goes to DONE.
- Result: acc = 1 + X + Y + X·Y_hi, where Y_hi is Y with all bits below the top 2L cleared (fractions in units of 1.0).
- DONE:
  - out_valid = 1.
  - If acc ≥ 2: Mantissa_Out = acc[FW : FW-MW+1] (the fraction of acc/2, truncated) and Shift = 1.
  - Otherwise: Mantissa_Out = acc[FW-1 : FW-MW] and Shift = 0.
  - On out_ready the block goes to IDLE.
- Outputs are registered, valid only in DONE and held stable while out_ready = 0.
- in_ready = 0 in ACCUM and DONE. There is no overlap between transactions.

## Timing
- Reset values: in_ready = 1, out_valid = 0, Mantissa_Out = 0, Shift = 0, state = IDLE, acc = 0, k = 0.
- Reset asserted in any state aborts the transaction immediately. No partial result is ever presented.
- Latency: out_valid rises L cycles after the accept edge (L = 0: in DONE on the cycle after the accept edge).
- Throughput with out_ready held at 1: one result per L+2 cycles (DONE → IDLE takes one cycle).
- Acc_Level is sampled only on the accept edge. Later changes do not affect a transaction in flight.
- in_valid asserted outside IDLE is ignored. The source must hold its data until in_ready is seen.

## Structure
- Shared package oaum_pkg holds:
  - the state enum (IDLE/ACCUM/DONE);
  - the FW calculation function;
  - the clamp-level function reused by other OAM blocks.
- Sub-module oaum_r4_step (combinational): inputs X, 2-bit digit and k; output is the aligned FW+2-bit addend X·d·2^-(2(k+1)).
- The top module contains the FSM, registers, accumulator adder and normaliser.

## Test plan
- X=0, Y=0, L=3 → out_valid 3 cycles after accept; Mantissa_Out=0, Shift=0.
- MW=15, X=Y=0x4000 (1.5·1.5), L=0 → Mantissa_Out=0x0000, Shift=1.
- Same operands, L=1 → 2.25 exactly; Mantissa_Out=0x1000, Shift=1, latency 1.
- X=Y=0x7FFF, L=0 → Mantissa_Out=0x3FFF, Shift=1.
- Random X, Y and L = 0..7 (MAX_ACC=4) versus the closed-form model 1+X+Y+X·Y_hi truncated; L>4 must match L=4 in both value and latency.
- Backpressure and reset:
  - out_ready low for 5 cycles in DONE → outputs stable, in_ready=0.
  - rst_n pulsed low mid-ACCUM → out_valid=0 and in_ready=1 immediately; the next transaction is correct.
